// File: rtl/ksa_sub_pipe_if.sv
// Handshake and data bundle for ksa_sub_pipe.
// master: the side that supplies operands and accepts results.
// slave : the subtractor pipeline itself.
interface ksa_sub_pipe_if #(
    parameter int unsigned SIZE_DATA = 32
);
    logic                 i_valid;
    logic                 o_ready;
    logic [SIZE_DATA-1:0] i_data_a;
    logic [SIZE_DATA-1:0] i_data_b;
    logic                 i_borrow;
    logic                 o_valid;
    logic                 i_ready;
    logic [SIZE_DATA-1:0] o_data_diff;
    logic                 o_borrow;
    logic                 o_zero;
    logic                 o_ovf;

    modport master (
        output i_valid, i_data_a, i_data_b, i_borrow, i_ready,
        input  o_ready, o_valid, o_data_diff, o_borrow, o_zero, o_ovf
    );

    modport slave (
        input  i_valid, i_data_a, i_data_b, i_borrow, i_ready,
        output o_ready, o_valid, o_data_diff, o_borrow, o_zero, o_ovf
    );
endinterface

// File: rtl/ksa_sub_pipe.sv
// Pipelined subtractor: diff = A - B - i_borrow (mod 2^SIZE_DATA).
// Each stage runs a CHUNK-bit Kogge-Stone prefix over its slice of A + ~B,
// with the slice carry registered between stages. Flow control is a plain
// valid chain: a stage loads when it is empty or its successor loads.
// Optional feature macro: KSA_SUB_FLAGS_EN (builds o_zero / o_ovf).
// SIZE_DATA must be a multiple of NUM_STAGE.
module ksa_sub_pipe #(
    parameter int unsigned SIZE_DATA = 32,
    parameter int unsigned NUM_STAGE = 2
) (
    input logic           i_clk,
    input logic           i_rst,
    ksa_sub_pipe_if.slave bus
);
    localparam int unsigned CHUNK = SIZE_DATA / NUM_STAGE;
    localparam int unsigned MSB   = SIZE_DATA - 1;

    // Per-stage registers
    logic [NUM_STAGE-1:0] valid_q;
    logic [NUM_STAGE-1:0] bor_q;
    logic [SIZE_DATA-1:0] diff_q [NUM_STAGE];
    logic [SIZE_DATA-1:0] a_q    [NUM_STAGE];
    logic [SIZE_DATA-1:0] nb_q   [NUM_STAGE];

    // Per-stage next values
    logic [NUM_STAGE-1:0] valid_d;
    logic [NUM_STAGE-1:0] bor_d;
    logic [SIZE_DATA-1:0] diff_d [NUM_STAGE];
    logic [SIZE_DATA-1:0] a_d    [NUM_STAGE];
    logic [SIZE_DATA-1:0] nb_d   [NUM_STAGE];

    logic [NUM_STAGE-1:0] load;
    logic                 load_acc;

    // Datapath scratch
    logic [SIZE_DATA-1:0] src_a;
    logic [SIZE_DATA-1:0] src_nb;
    logic [SIZE_DATA-1:0] src_diff;
    logic                 src_cin;
    logic                 src_valid;
    logic [CHUNK:0]       slice_sum;
    int unsigned          prev;

    logic                 unused_bits;

    // CHUNK-bit Kogge-Stone add with carry-in; returns {carry_out, sum}
    function automatic logic [CHUNK:0] ks_add(
        input logic [CHUNK-1:0] a_in,
        input logic [CHUNK-1:0] nb_in,
        input logic             cin
    );
        logic [CHUNK-1:0] p0;
        logic [CHUNK-1:0] g;
        logic [CHUNK-1:0] p;
        logic [CHUNK-1:0] g_n;
        logic [CHUNK-1:0] p_n;
        logic [CHUNK:0]   c;
        p0 = a_in ^ nb_in;
        g  = a_in & nb_in;
        p  = p0;
        for (int unsigned d = 1; d < CHUNK; d = d * 2) begin
            g_n = g;
            p_n = p;
            for (int unsigned i = d; i < CHUNK; i++) begin
                g_n[i] = g[i] | (p[i] & g[i-d]);
                p_n[i] = p[i] & p[i-d];
            end
            g = g_n;
            p = p_n;
        end
        c[0] = cin;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            c[i+1] = g[i] | (p[i] & cin);
        end
        return {c[CHUNK], p0 ^ c[CHUNK-1:0]};
    endfunction

    // Load enables: stage s loads if any stage from s to the last is empty, or downstream takes
    always_comb begin
        load     = '0;
        load_acc = 1'b0;
        for (int unsigned s = 0; s < NUM_STAGE; s++) begin
            load_acc = bus.i_ready;
            for (int unsigned k = s; k < NUM_STAGE; k++) begin
                load_acc = load_acc | ~valid_q[k];
            end
            load[s] = load_acc;
        end
    end

    // Slice arithmetic for every stage, fed from the bus or the previous stage register.
    // The inter-stage carry is kept in borrow sense (inverted) so every register clears to 0.
    always_comb begin
        valid_d   = '0;
        bor_d     = '0;
        diff_d    = '{default: '0};
        a_d       = '{default: '0};
        nb_d      = '{default: '0};
        src_a     = '0;
        src_nb    = '0;
        src_diff  = '0;
        src_cin   = 1'b0;
        src_valid = 1'b0;
        slice_sum = '0;
        prev      = 0;
        for (int unsigned s = 0; s < NUM_STAGE; s++) begin
            prev = (s == 0) ? 0 : s - 1;
            if (s == 0) begin
                src_a     = bus.i_data_a;
                src_nb    = ~bus.i_data_b;
                src_diff  = '0;
                src_cin   = ~bus.i_borrow;
                src_valid = bus.i_valid;
            end else begin
                src_a     = a_q[prev];
                src_nb    = nb_q[prev];
                src_diff  = diff_q[prev];
                src_cin   = ~bor_q[prev];
                src_valid = valid_q[prev];
            end
            slice_sum = ks_add(src_a[s*CHUNK +: CHUNK], src_nb[s*CHUNK +: CHUNK], src_cin);
            valid_d[s]                   = src_valid;
            a_d[s]                       = src_a;
            nb_d[s]                      = src_nb;
            diff_d[s]                    = src_diff;
            diff_d[s][s*CHUNK +: CHUNK]  = slice_sum[CHUNK-1:0];
            bor_d[s]                     = ~slice_sum[CHUNK];
        end
    end

    // Stage registers: valid follows the load enable, payload only captures valid data
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= '0;
            bor_q   <= '0;
            for (int unsigned s = 0; s < NUM_STAGE; s++) begin
                diff_q[s] <= '0;
                a_q[s]    <= '0;
                nb_q[s]   <= '0;
            end
        end else begin
            for (int unsigned s = 0; s < NUM_STAGE; s++) begin
                if (load[s]) begin
                    valid_q[s] <= valid_d[s];
                    if (valid_d[s]) begin
                        diff_q[s] <= diff_d[s];
                        a_q[s]    <= a_d[s];
                        nb_q[s]   <= nb_d[s];
                        bor_q[s]  <= bor_d[s];
                    end
                end
            end
        end
    end

`ifdef KSA_SUB_FLAGS_EN
    logic zero_q;
    logic ovf_q;
    logic zero_d;
    logic ovf_d;

    // Result flags computed on the final stage's full difference
    always_comb begin
        zero_d = (diff_d[NUM_STAGE-1] == '0);
        ovf_d  = (a_d[NUM_STAGE-1][MSB] != ~nb_d[NUM_STAGE-1][MSB]) &&
                 (diff_d[NUM_STAGE-1][MSB] != a_d[NUM_STAGE-1][MSB]);
    end

    // Flags registered alongside the last stage so they share its latency and stall behaviour
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (load[NUM_STAGE-1] && valid_d[NUM_STAGE-1]) begin
            zero_q <= zero_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bus.o_zero = zero_q;
    assign bus.o_ovf  = ovf_q;
`else
    assign bus.o_zero = 1'b0;
    assign bus.o_ovf  = 1'b0;
`endif

    // Operand bits already consumed by earlier slices are carried but never read again
    always_comb begin
        unused_bits = 1'b0;
        for (int unsigned s = 0; s < NUM_STAGE; s++) begin
            unused_bits = unused_bits ^ (^a_q[s]) ^ (^nb_q[s]);
        end
    end

    assign bus.o_ready     = load[0];
    assign bus.o_valid     = valid_q[NUM_STAGE-1];
    assign bus.o_data_diff = diff_q[NUM_STAGE-1];
    assign bus.o_borrow    = bor_q[NUM_STAGE-1];

endmodule

// File: tb/tb_ksa_sub_pipe.sv
// Self-checking bench for ksa_sub_pipe (SIZE_DATA=32, NUM_STAGE=2).
// Expected results come from plain wide arithmetic queued at input handshakes.
module tb_ksa_sub_pipe;
    localparam int unsigned SZ = 32;
    localparam int unsigned NS = 2;
`ifdef KSA_SUB_FLAGS_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif

    typedef struct packed {
        logic [SZ-1:0] diff;
        logic          borrow;
        logic          zero;
        logic          ovf;
    } res_t;

    typedef struct packed {
        logic [SZ-1:0] a;
        logic [SZ-1:0] b;
        logic          br;
        logic [SZ-1:0] d;
        logic          bo;
        logic          z;
        logic          o;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    res_t exp_q[$];

    always #5 clk = ~clk;

    ksa_sub_pipe_if #(.SIZE_DATA(SZ)) bus ();

    ksa_sub_pipe #(.SIZE_DATA(SZ), .NUM_STAGE(NS)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    function automatic res_t model(input logic [SZ-1:0] a, input logic [SZ-1:0] b, input logic br);
        logic [SZ:0] w;
        res_t r;
        w = {1'b0, a} - {1'b0, b} - {{SZ{1'b0}}, br};
        r.diff   = w[SZ-1:0];
        r.borrow = w[SZ];
        r.zero   = FLAGS_ON && (w[SZ-1:0] == 0);
        r.ovf    = FLAGS_ON && (a[SZ-1] != b[SZ-1]) && (w[SZ-1] != a[SZ-1]);
        return r;
    endfunction

    // One clock: drive inputs after the falling edge, sample outputs 1 time unit later.
    task automatic step(input logic v, input logic [SZ-1:0] a, input logic [SZ-1:0] b,
                        input logic br, input logic rdy,
                        output logic took, output logic ov, output res_t got);
        bus.i_valid  = v;
        bus.i_data_a = a;
        bus.i_data_b = b;
        bus.i_borrow = br;
        bus.i_ready  = rdy;
        #1;
        took = v && (bus.o_ready === 1'b1);
        ov   = (bus.o_valid === 1'b1);
        got  = {bus.o_data_diff, bus.o_borrow, bus.o_zero, bus.o_ovf};
        if (took) exp_q.push_back(model(a, b, br));
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [SZ-1:0] pick_operand();
        case ($urandom_range(0, 3))
            0:       return SZ'($urandom_range(0, 15));
            1:       return {1'b1, SZ'($urandom_range(0, 3))} ;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        bus.i_valid  = 1'b0;
        bus.i_data_a = '0;
        bus.i_data_b = '0;
        bus.i_borrow = 1'b0;
        bus.i_ready  = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL reset o_valid: got %b want 0", bus.o_valid); end
        checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL reset o_ready: got %b want 1", bus.o_ready); end
        checks++; if (bus.o_data_diff !== '0) begin errors++; $display("FAIL reset o_data_diff: got %h want 0", bus.o_data_diff); end
        checks++; if (bus.o_borrow !== 1'b0) begin errors++; $display("FAIL reset o_borrow: got %b want 0", bus.o_borrow); end
        checks++; if (bus.o_zero !== 1'b0) begin errors++; $display("FAIL reset o_zero: got %b want 0", bus.o_zero); end
        checks++; if (bus.o_ovf !== 1'b0) begin errors++; $display("FAIL reset o_ovf: got %b want 0", bus.o_ovf); end
        @(negedge clk);
    endtask

    task automatic test_directed();
        vec_t vecs[7];
        logic took, ov;
        res_t got, e;
        int   lat;
        vecs[0] = {32'h0000_000A, 32'h0000_0003, 1'b0, 32'h0000_0007, 1'b0, 1'b0, 1'b0};
        vecs[1] = {32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
        vecs[2] = {32'h0000_0005, 32'h0000_0005, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
        vecs[3] = {32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1};
        vecs[4] = {32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
        vecs[5] = {32'h0001_0000, 32'h0000_0001, 1'b0, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0};
        vecs[6] = {32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 7; i++) begin
            step(1'b1, vecs[i].a, vecs[i].b, vecs[i].br, 1'b1, took, ov, got);
            checks++; if (!took) begin errors++; $display("FAIL directed[%0d] accept: got 0 want 1", i); end
            lat = -1;
            for (int n = 1; n <= 20 && lat < 0; n++) begin
                step(1'b0, '0, '0, 1'b0, 1'b1, took, ov, got);
                if (ov) lat = n;
            end
            checks++;
            if (lat != int'(NS)) begin
                errors++; $display("FAIL directed[%0d] latency: got %0d want %0d", i, lat, NS);
            end
            if (lat > 0) begin
                checks++; if (got.diff !== vecs[i].d) begin errors++; $display("FAIL directed[%0d] diff: got %h want %h", i, got.diff, vecs[i].d); end
                checks++; if (got.borrow !== vecs[i].bo) begin errors++; $display("FAIL directed[%0d] borrow: got %b want %b", i, got.borrow, vecs[i].bo); end
                checks++; if (got.zero !== (FLAGS_ON & vecs[i].z)) begin errors++; $display("FAIL directed[%0d] zero: got %b want %b", i, got.zero, FLAGS_ON & vecs[i].z); end
                checks++; if (got.ovf !== (FLAGS_ON & vecs[i].o)) begin errors++; $display("FAIL directed[%0d] ovf: got %b want %b", i, got.ovf, FLAGS_ON & vecs[i].o); end
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    checks++; if (got !== e) begin errors++; $display("FAIL directed[%0d] model: got %h want %h", i, got, e); end
                end
            end
            exp_q.delete();
        end
    endtask

    task automatic test_random_stream();
        logic v, rdy, took, ov, prev_stall;
        res_t got, e, prev_got;
        prev_stall = 1'b0;
        prev_got   = '0;
        for (int c = 0; c < 300; c++) begin
            v   = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            step(v, pick_operand(), pick_operand(), 1'($urandom_range(0, 1)), rdy, took, ov, got);
            if (prev_stall) begin
                checks++;
                if (!ov || got !== prev_got) begin
                    errors++; $display("FAIL stall_hold: got v=%b %h want v=1 %h", ov, got, prev_got);
                end
            end
            if (ov && rdy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL random unexpected output: got %h want none", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin errors++; $display("FAIL random result: got %h want %h", got, e); end
                end
            end
            prev_stall = ov && !rdy;
            prev_got   = got;
        end
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            step(1'b0, '0, '0, 1'b0, 1'b1, took, ov, got);
            if (ov) begin
                e = exp_q.pop_front();
                checks++; if (got !== e) begin errors++; $display("FAIL random drain: got %h want %h", got, e); end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL random leftover: got %0d want 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [SZ-1:0] av[8];
        logic [SZ-1:0] bv[8];
        logic          brv[8];
        logic          took, ov, have_ref;
        res_t          got, e, ref_got;
        int            idx, outs;
        for (int i = 0; i < 8; i++) begin
            av[i] = $urandom; bv[i] = $urandom; brv[i] = 1'($urandom_range(0, 1));
        end
        idx = 0; outs = 0; have_ref = 1'b0; ref_got = '0;
        for (int c = 0; c < 5; c++) begin
            step(idx < 8, av[idx % 8], bv[idx % 8], brv[idx % 8], 1'b0, took, ov, got);
            if (took) idx++;
            if (ov) begin
                if (have_ref) begin
                    checks++; if (got !== ref_got) begin errors++; $display("FAIL backpressure hold: got %h want %h", got, ref_got); end
                end
                have_ref = 1'b1; ref_got = got;
            end
            if (c == 4) begin
                checks++; if (took) begin errors++; $display("FAIL backpressure o_ready: got 1 want 0"); end
            end
        end
        checks++; if (idx != int'(NS)) begin errors++; $display("FAIL backpressure accepted: got %0d want %0d", idx, NS); end
        for (int c = 0; c < 40 && outs < 8; c++) begin
            step(idx < 8, av[idx % 8], bv[idx % 8], brv[idx % 8], 1'b1, took, ov, got);
            if (took) idx++;
            if (ov) begin
                outs++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL backpressure unexpected: got %h want none", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin errors++; $display("FAIL backpressure result: got %h want %h", got, e); end
                end
            end
        end
        checks++; if (outs != 8) begin errors++; $display("FAIL backpressure count: got %0d want 8", outs); end
        exp_q.delete();
    endtask

    task automatic test_reset_midstream();
        logic took, ov;
        res_t got, e;
        int   lat;
        step(1'b1, 32'h0000_0100, 32'h0000_0001, 1'b0, 1'b1, took, ov, got);
        step(1'b1, 32'h0000_0200, 32'h0000_0002, 1'b0, 1'b1, took, ov, got);
        bus.i_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        #1;
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL midreset o_valid: got %b want 0", bus.o_valid); end
        checks++; if (bus.o_data_diff !== '0 || bus.o_borrow !== 1'b0) begin
            errors++; $display("FAIL midreset outputs: got %h/%b want 0/0", bus.o_data_diff, bus.o_borrow);
        end
        checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL midreset o_ready: got %b want 1", bus.o_ready); end
        @(negedge clk);
        step(1'b1, 32'h0000_0010, 32'h0000_0020, 1'b1, 1'b1, took, ov, got);
        lat = -1;
        for (int n = 1; n <= 20 && lat < 0; n++) begin
            step(1'b0, '0, '0, 1'b0, 1'b1, took, ov, got);
            if (ov) lat = n;
        end
        checks++; if (lat != int'(NS)) begin errors++; $display("FAIL midreset latency: got %0d want %0d", lat, NS); end
        e = model(32'h0000_0010, 32'h0000_0020, 1'b1);
        checks++; if (got !== e) begin errors++; $display("FAIL midreset result: got %h want %h", got, e); end
        checks++; if (got.diff !== 32'hFFFF_FFEF) begin errors++; $display("FAIL midreset diff: got %h want ffffffef", got.diff); end
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_random_stream();
        test_back_to_back();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
